uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_fsm.sv | 132 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants used by the controller and its sibling blocks.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int PRESCALE           = 8;
  localparam int SAMPLE_STROBE_EDGE = 6;
  localparam int DATA_WIDTH_DEF     = 8;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start/data/parity/stop bits using the
// external edge/bit counters and reports each frame as valid or errored.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic [2:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       cnt_enable,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  state_t state;
  state_t next_state;
  logic   par_en_q;
  logic   strt_glitch_q;
  logic   par_err_q;
  logic   stp_err_q;
  logic   last_edge;
  logic   strobe_edge;
  logic   enter_start;

  assign last_edge   = (edge_cnt == 3'(PRESCALE - 1));
  assign strobe_edge = (edge_cnt == 3'(SAMPLE_STROBE_EDGE));
  assign enter_start = (next_state == START) && (state != START);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; bit_cnt is only consulted on the last data bit
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!rx_in) next_state = START;
        else        next_state = IDLE;
      end
      START: begin
        if (last_edge) next_state = strt_glitch_q ? IDLE : DATA;
        else           next_state = START;
      end
      DATA: begin
        if (last_edge && (bit_cnt == 4'(DATA_WIDTH))) next_state = par_en_q ? PARITY : STOP;
        else                                          next_state = DATA;
      end
      PARITY: begin
        if (last_edge) next_state = STOP;
        else           next_state = PARITY;
      end
      STOP: begin
        if (last_edge) next_state = DONE;
        else           next_state = STOP;
      end
      DONE: begin
        if (!rx_in) next_state = START;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode from registered state; strobes fire once per bit after the majority samples
  always_comb begin
    cnt_enable  = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      START, DATA, PARITY, STOP: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = strobe_edge && (state == START);
        deser_en    = strobe_edge && (state == DATA);
        par_chk_en  = strobe_edge && (state == PARITY);
        stp_chk_en  = strobe_edge && (state == STOP);
      end
      DONE: begin
        data_valid = !(par_err_q | stp_err_q);
        frame_err  = par_err_q | stp_err_q;
      end
      default: begin
        busy = (state != IDLE);
      end
    endcase
  end

  // Per-frame flags: cleared and par_en captured on every entry to START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q      <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else if (enter_start) begin
      par_en_q      <= par_en;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      if (strt_chk_en) strt_glitch_q <= strt_glitch;
      if (par_chk_en)  par_err_q     <= par_err & par_en_q;
      if (stp_chk_en)  stp_err_q     <= stp_err;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the external edge/bit counters, plays a table
// of frames and scores data_valid/frame_err against an expected-result queue.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [2:0] edge_cnt = 3'd0;
  logic [3:0] bit_cnt = 4'd0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_err, busy;

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .cnt_enable(cnt_enable),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         glitch;
    bit         perr;
    bit         serr;
    bit         b2b;
    int         abort_bit;
    bit         exp_valid;
    bit         exp_err;
    int         exp_deser;
    int         exp_strt;
    int         exp_par;
    int         exp_stp;
  } vec_t;

  typedef struct {
    bit valid;
    bit err;
  } result_t;

  vec_t    vecs[10];
  result_t sb[$];
  int      n_checks = 0;
  int      n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int all_outputs();
    return int'({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                 stp_chk_en, data_valid, frame_err, busy});
  endfunction

  function automatic logic rx_bit(input logic [7:0] d, input bit pe, input logic [3:0] b);
    if (b == 4'd0) return 1'b0;
    if (b <= 4'd8) return d[b - 4'd1];
    if (b == 4'd9 && pe) return ^d;
    return 1'b1;
  endfunction

  // One clock: counters advance only if enabled before the edge, otherwise clear
  task automatic step();
    logic ce;
    ce = cnt_enable;
    @(posedge clk);
    #1;
    if (ce) begin
      if (edge_cnt == 3'd7) begin
        edge_cnt = 3'd0;
        bit_cnt  = bit_cnt + 4'd1;
      end else begin
        edge_cnt = edge_cnt + 3'd1;
      end
    end else begin
      edge_cnt = 3'd0;
      bit_cnt  = 4'd0;
    end
  endtask

  task automatic run_frame(input vec_t v);
    int deser = 0, strt = 0, par = 0, stp = 0, pulses = 0;
    bit prev_e7 = 1'b0, after_done = 1'b0, finished = 1'b0;
    result_t r;
    par_en      = v.par_en;
    strt_glitch = v.glitch;
    par_err     = v.perr;
    stp_err     = v.serr;
    if (!v.glitch && v.abort_bit == 0) sb.push_back('{v.exp_valid, v.exp_err});
    rx_in = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      step();
      #1;
      if (cyc == 0) check("start_busy", busy, 1);
      if (after_done && !v.b2b) check("busy_after_done", busy, 0);
      after_done = 1'b0;
      if (deser_en | strt_chk_en | par_chk_en | stp_chk_en) check("strobe_edge", edge_cnt, 6);
      deser += int'(deser_en);
      strt  += int'(strt_chk_en);
      par   += int'(par_chk_en);
      stp   += int'(stp_chk_en);
      check("cnt_enable", cnt_enable, int'(busy && !(data_valid | frame_err)));
      if (data_valid | frame_err) begin
        pulses++;
        check("one_result", int'(data_valid) + int'(frame_err), 1);
        check("done_after_stop_e7", prev_e7, 1);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          r = sb.pop_front();
          check("data_valid", data_valid, r.valid);
          check("frame_err", frame_err, r.err);
        end
        after_done = 1'b1;
        if (v.b2b) begin
          rx_in    = 1'b0;
          finished = 1'b1;
        end else begin
          rx_in = 1'b1;
        end
      end else if (cyc > 0 && !busy) begin
        rx_in    = 1'b1;
        finished = 1'b1;
      end else if (v.glitch) begin
        rx_in = (cyc < 3) ? 1'b0 : 1'b1;
      end else begin
        rx_in = rx_bit(v.data, v.par_en, bit_cnt);
      end
      if (v.abort_bit != 0 && busy && bit_cnt == 4'(v.abort_bit) && edge_cnt == 3'd3) begin
        rst = 1'b0;
        #1;
        check("reset_mid_frame_outputs", all_outputs(), 0);
        rx_in = 1'b1;
        repeat (2) step();
        check("reset_held_outputs", all_outputs(), 0);
        #2 rst = 1'b1;
        repeat (3) step();
        check("idle_after_reset_release", busy, 0);
        return;
      end
      prev_e7 = (stp > 0) && (edge_cnt == 3'd7) && cnt_enable;
    end
    if (!finished) check("frame_timeout", 0, 1);
    check("deser_count", deser, v.exp_deser);
    check("strt_chk_count", strt, v.exp_strt);
    check("par_chk_count", par, v.exp_par);
    check("stp_chk_count", stp, v.exp_stp);
    check("result_pulses", pulses, (v.glitch ? 0 : 1));
  endtask

  initial begin
    //          data   pe  gl  pe  se  b2b abort val err des st pa sp
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8, 1, 1, 1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8, 1, 1, 1};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1, 0, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8, 1, 0, 1};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8, 1, 0, 1};
    vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8, 1, 1, 1};
    vecs[7] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8, 1, 0, 1};
    vecs[8] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8, 1, 0, 1};
    vecs[9] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8, 1, 1, 1};

    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b1;
    repeat (3) step();
    #1;
    check("idle_with_line_high", busy, 0);

    for (int i = 0; i < 10; i++) run_frame(vecs[i]);

    rx_in = 1'b1;
    repeat (3) step();
    #1;
    check("final_idle", all_outputs(), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
